// File: rtl/debug_uart_rx_pkg.sv
// Shared types and helpers for the debug UART receiver and transmitter.
// Holds the receiver state encoding and the bit-period calculation.
package debug_uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   function automatic int cycles_per_bit(
      input int clk_hz,
      input int bit_rate
   );
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/debug_uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to all ones so an idle-high line never looks like a start bit.
module uart_rx_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 debug UART receiver with a one-entry holding register.
// Mid-bit sampling; sticky overrun and frame-error flags cleared by ack.
module debug_uart_rx
   import debug_uart_pkg::*;
#(
   parameter int CLK_HZ   = 25_000_000,
   parameter int BIT_RATE = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_busy,
   output logic       rx_overrun,
   output logic       rx_frame_error
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CW             = $clog2(CYCLES_PER_BIT);

   localparam logic [CW-1:0] CNT_FULL = CW'(CYCLES_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   if (CYCLES_PER_BIT < 4) begin : g_rate_check
      $error("debug_uart_rx: CLK_HZ/BIT_RATE must be at least 4");
   end

   logic            w_rxs;
   rx_state_t       r_state;
   rx_state_t       w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      r_bit;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic            w_load;
   logic            w_ferr;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_overrun;
   logic            r_ferr;

   uart_rx_sync #(
      .W (1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (uart_rxd),
      .o_q (w_rxs)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_load      = 1'b0;
      w_ferr      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = START;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
            end
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
                  w_bit_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         DATA: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {w_rxs, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_state_nxt = STOP;
                  w_bit_nxt   = '0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         STOP: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_load      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = WAIT_HIGH;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (w_rxs) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
         end
      endcase
   end

   // A load beats a simultaneous ack; ack always clears the sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         if (w_load && (!r_valid || rx_ack)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (rx_ack) begin
            r_valid <= 1'b0;
         end
         if (rx_ack) begin
            r_overrun <= 1'b0;
         end else if (w_load && r_valid) begin
            r_overrun <= 1'b1;
         end
         if (rx_ack) begin
            r_ferr <= 1'b0;
         end else if (w_ferr) begin
            r_ferr <= 1'b1;
         end
      end
   end

   assign rx_data        = r_data;
   assign rx_valid       = r_valid;
   assign rx_overrun     = r_overrun;
   assign rx_frame_error = r_ferr;
   assign rx_busy        = (r_state != IDLE);

endmodule
